// File: rtl/wb_uart_pkg.sv
// Shared constants and state types for the Wishbone UART responder.
// Offsets are indices on address[4:2]; INT_EN decodes only with WB_UART_IRQ_EN.
package wb_uart_pkg;

  localparam logic [2:0] OFS_TXDATA = 3'd0;
  localparam logic [2:0] OFS_RXDATA = 3'd1;
  localparam logic [2:0] OFS_STATUS = 3'd2;
  localparam logic [2:0] OFS_BAUD   = 3'd3;
  localparam logic [2:0] OFS_INTEN  = 3'd4;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_FERR  = 6;

  localparam int IE_RX_VALID = 0;
  localparam int IE_TX_EMPTY = 1;
  localparam int IE_ERR      = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone classic-cycle bundle; data_in is write data, data_out is read data.
interface wishbone_if;
  logic        cycle;
  logic        strobe;
  logic        write_enable;
  logic [31:0] address;
  logic [3:0]  select;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport slave  (input cycle, strobe, write_enable, address, select, data_in,
                  output data_out, ack);
  modport master (output cycle, strobe, write_enable, address, select, data_in,
                  input data_out, ack);
endinterface

// File: rtl/wb_uart_fifo.sv
// Synchronous byte FIFO with first-word fall-through read port.
// Pointers carry one extra wrap bit to tell full from empty.
module wb_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wp, r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push, w_pop;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/wb_uart_responder.sv
// Wishbone-mapped 8N1 UART: TX FIFO, single-byte RX holding register, baud divider.
// Define WB_UART_IRQ_EN to add the INT_EN register and the irq output.
import wb_uart_pkg::*;

module wb_uart_responder #(
  parameter int          TX_DEPTH    = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic      clk,
  input  logic      rst_n,
  wishbone_if.slave wb,
  output logic      uart_tx,
  input  logic      uart_rx
`ifdef WB_UART_IRQ_EN
  ,
  output logic      irq
`endif
);

  // bus side
  logic        r_ack;
  logic [31:0] r_dout;
  logic [15:0] r_div;
  logic        w_req, w_wr, w_rd;
  logic [2:0]  w_ofs;
  logic [31:0] w_rdata;
  logic [6:0]  w_status;
  logic        w_push_req, w_rx_rd, w_w1c;
  logic        w_unused;

  // tx side
  logic        w_full, w_empty, w_pop, w_tx_busy;
  logic [7:0]  w_fifo_dout;
  tx_state_t   r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_sh;
  logic        r_tx;
  logic        r_tx_ovf;

  // rx side
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t   r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;
  logic [7:0]  r_rx_byte;
  logic        r_rx_valid, r_rx_ovr, r_rx_ferr;
  logic        w_rx_done;

  assign w_req      = wb.cycle & wb.strobe & ~r_ack;
  assign w_ofs      = wb.address[4:2];
  assign w_wr       = w_req & wb.write_enable;
  assign w_rd       = w_req & ~wb.write_enable;
  assign w_push_req = w_wr && (w_ofs == OFS_TXDATA) && wb.select[0];
  assign w_rx_rd    = w_rd && (w_ofs == OFS_RXDATA);
  assign w_w1c      = w_wr && (w_ofs == OFS_STATUS);
  assign w_unused   = ^{wb.address[31:5], wb.address[1:0], wb.select[3:2], wb.data_in[31:16]};

  assign wb.ack      = r_ack;
  assign wb.data_out = r_dout;
  assign uart_tx     = r_tx;

  assign w_pop     = (r_tx_state == TX_IDLE) & ~w_empty;
  assign w_tx_busy = (r_tx_state != TX_IDLE) | ~w_empty;
  assign w_rx_done = (r_rx_state == RX_STOP) && (r_rx_cnt == 16'd0);

  always_comb begin
    w_status              = '0;
    w_status[ST_TX_FULL]  = w_full;
    w_status[ST_TX_EMPTY] = w_empty;
    w_status[ST_RX_VALID] = r_rx_valid;
    w_status[ST_RX_OVR]   = r_rx_ovr;
    w_status[ST_TX_BUSY]  = w_tx_busy;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_RX_FERR]  = r_rx_ferr;
  end

`ifdef WB_UART_IRQ_EN
  logic [2:0] r_inten;
  logic       r_irq;
  logic [2:0] w_irq_src;

  assign irq = r_irq;

  always_comb begin
    w_irq_src              = '0;
    w_irq_src[IE_RX_VALID] = r_rx_valid;
    w_irq_src[IE_TX_EMPTY] = w_empty;
    w_irq_src[IE_ERR]      = r_rx_ovr | r_tx_ovf | r_rx_ferr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inten <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr && (w_ofs == OFS_INTEN) && wb.select[0]) r_inten <= wb.data_in[2:0];
      r_irq <= |(r_inten & w_irq_src);
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      OFS_RXDATA: w_rdata = {23'b0, r_rx_valid, r_rx_byte};
      OFS_STATUS: w_rdata = {25'b0, w_status};
      OFS_BAUD:   w_rdata = {16'b0, r_div};
`ifdef WB_UART_IRQ_EN
      OFS_INTEN:  w_rdata = {29'b0, r_inten};
`endif
      default:    w_rdata = '0;
    endcase
  end

  // every side effect is keyed on w_req, i.e. the edge that raises ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack  <= 1'b0;
      r_dout <= '0;
      r_div  <= DEFAULT_DIV;
    end else begin
      r_ack  <= w_req;
      r_dout <= w_rd ? w_rdata : 32'd0;
      if (w_wr && (w_ofs == OFS_BAUD)) begin
        if (wb.select[0]) r_div[7:0]  <= wb.data_in[7:0];
        if (wb.select[1]) r_div[15:8] <= wb.data_in[15:8];
      end
    end
  end

  wb_uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_txq (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push_req),
    .i_din  (wb.data_in[7:0]),
    .i_pop  (w_pop),
    .o_dout (w_fifo_dout),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // TX: the divider is reloaded only at bit boundaries so a BAUD write never splits a bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (w_pop) begin
          r_tx_sh    <= w_fifo_dout;
          r_tx       <= 1'b0;
          r_tx_cnt   <= r_div;
          r_tx_state <= TX_START;
        end
        TX_START: if (r_tx_cnt == 16'd0) begin
          r_tx       <= r_tx_sh[0];
          r_tx_sh    <= {1'b0, r_tx_sh[7:1]};
          r_tx_bit   <= '0;
          r_tx_cnt   <= r_div;
          r_tx_state <= TX_DATA;
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        TX_DATA: if (r_tx_cnt == 16'd0) begin
          r_tx_cnt <= r_div;
          if (r_tx_bit == 3'd7) begin
            r_tx       <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx     <= r_tx_sh[0];
            r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
            r_tx_bit <= r_tx_bit + 3'd1;
          end
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        TX_STOP: if (r_tx_cnt == 16'd0) r_tx_state <= TX_IDLE;
                 else r_tx_cnt <= r_tx_cnt - 16'd1;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX: sync chain resets high so reset release never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
          r_rx_cnt   <= {1'b0, r_div[15:1]};
          r_rx_state <= RX_START;
        end
        RX_START: if (r_rx_cnt == 16'd0) begin
          r_rx_cnt   <= r_div;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        RX_DATA: if (r_rx_cnt == 16'd0) begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_cnt <= r_div;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          else                  r_rx_bit   <= r_rx_bit + 3'd1;
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        RX_STOP: if (r_rx_cnt == 16'd0) r_rx_state <= RX_IDLE;
                 else r_rx_cnt <= r_rx_cnt - 16'd1;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // sticky flags: a new event in the same cycle as its W1C clear is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_tx_ovf   <= 1'b0;
    end else begin
      if (w_rx_done && r_rx_s2 && !r_rx_valid) begin
        r_rx_byte  <= r_rx_sh;
        r_rx_valid <= 1'b1;
      end else if (w_rx_rd) r_rx_valid <= 1'b0;

      if (w_rx_done && r_rx_s2 && r_rx_valid)   r_rx_ovr <= 1'b1;
      else if (w_w1c && wb.data_in[ST_RX_OVR])  r_rx_ovr <= 1'b0;

      if (w_rx_done && !r_rx_s2)                r_rx_ferr <= 1'b1;
      else if (w_w1c && wb.data_in[ST_RX_FERR]) r_rx_ferr <= 1'b0;

      if (w_push_req && w_full)                 r_tx_ovf <= 1'b1;
      else if (w_w1c && wb.data_in[ST_TX_OVF])  r_tx_ovf <= 1'b0;
    end
  end

endmodule
